// File: rtl/eeprom_i2c_slave_pkg.sv
// Shared types and constants for the I2C EEPROM slave.
package eeprom_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADR7     = 3'd1,
      S_DEV      = 3'd2,
      S_AHI      = 3'd3,
      S_ALO      = 3'd4,
      S_WRITE    = 3'd5,
      S_READ     = 3'd6,
      S_NACKWAIT = 3'd7
   } state_e;

   localparam logic [1:0] MODE_24C01 = 2'd0;  // 7-bit address in first byte
   localparam logic [1:0] MODE_24C02 = 2'd1;  // block bits in device byte
   localparam logic [1:0] MODE_24C32 = 2'd2;  // two address bytes (3 aliases this)

   localparam logic [3:0] DEV_CODE = 4'b1010;

   // Modes 2 and 3 both use two address bytes and chip-select matching.
   function automatic logic is_two_byte(input logic [1:0] m);
      return m[1];
   endfunction

endpackage

// File: rtl/eeprom_i2c_slave_bus_monitor.sv
// Glitch filter plus START/STOP and SCL edge detection for the I2C bus.
module i2c_bus_monitor #(
   parameter int unsigned FILT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic scl,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_hi_o
);

   localparam int unsigned H = FILT / 2;

   logic [FILT-1:0] scl_q;
   logic [FILT-1:0] sda_q;
   logic            scl_r, scl_f, scl_h, sda_r, sda_f;

   // Shift one sample per enabled clock; the idle bus reads as all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else if (en) begin
         scl_q <= {scl_q[FILT-2:0], scl};
         sda_q <= {sda_q[FILT-2:0], sda_i};
      end
   end

   // Older half vs newer half decides an edge; events only count on enabled samples
   // so a held filter cannot report the same edge twice.
   always_comb begin
      scl_r      = (scl_q[FILT-1:H] == '0) && (scl_q[H-1:0] == '1);
      scl_f      = (scl_q[FILT-1:H] == '1) && (scl_q[H-1:0] == '0);
      scl_h      = (scl_q == '1);
      sda_r      = (sda_q[FILT-1:H] == '0) && (sda_q[H-1:0] == '1);
      sda_f      = (sda_q[FILT-1:H] == '1) && (sda_q[H-1:0] == '0);
      scl_rise_o = en && scl_r;
      scl_fall_o = en && scl_f;
      start_o    = en && sda_f && scl_h;
      stop_o     = en && sda_r && scl_h;
      sda_hi_o   = (sda_q == '1);
   end

endmodule

// File: rtl/eeprom_i2c_slave.sv
// I2C EEPROM slave front-end driving a synchronous byte-wide BRAM.
module eeprom_i2c_slave
   import eeprom_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned FILT   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] mask,
   input  logic [2:0]        page_bits,
   input  logic [2:0]        dev_sel,
   input  logic              wp,
   input  logic              scl,
   input  logic              sda_i,
   output logic              sda_o,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_d,
   output logic              ram_wr,
   output logic              ram_rd,
   input  logic [7:0]        ram_q,
   output logic [2:0]        dbg_state
);

   localparam int unsigned HI_W = ADDR_W - 8;

   logic scl_rise, scl_fall, start_ev, stop_ev, sda_hi;

   i2c_bus_monitor #(.FILT(FILT)) u_mon (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .scl        (scl),
      .sda_i      (sda_i),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_ev),
      .stop_o     (stop_ev),
      .sda_hi_o   (sda_hi)
   );

   state_e            state_q, state_d;
   logic [2:0]        bitcnt_q, bitcnt_d, bit_nxt;
   logic              ack_slot_q, ack_slot_d;
   logic              bit_seen_q, bit_seen_d;
   logic              rw_q, rw_d;
   logic              mack_q, mack_d;
   logic [7:0]        sh_q, sh_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        ram_d_q, ram_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d, pmask;
   logic              sda_q, sda_d;
   logic              ram_wr_q, ram_wr_d;
   logic              ram_rd_q, ram_rd_d;
   logic              rd_p1_q, rd_p1_d;
   logic              wr_inc_q, wr_inc_d;
   logic              dev_match;

   // Registers; reset presents an idle, released bus and a cleared address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bitcnt_q   <= 3'd7;
         ack_slot_q <= 1'b0;
         bit_seen_q <= 1'b0;
         rw_q       <= 1'b0;
         mack_q     <= 1'b0;
         sh_q       <= '0;
         tx_q       <= '0;
         ram_d_q    <= '0;
         addr_q     <= '0;
         sda_q      <= 1'b1;
         ram_wr_q   <= 1'b0;
         ram_rd_q   <= 1'b0;
         rd_p1_q    <= 1'b0;
         wr_inc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         ack_slot_q <= ack_slot_d;
         bit_seen_q <= bit_seen_d;
         rw_q       <= rw_d;
         mack_q     <= mack_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         ram_d_q    <= ram_d_d;
         addr_q     <= addr_d;
         sda_q      <= sda_d;
         ram_wr_q   <= ram_wr_d;
         ram_rd_q   <= ram_rd_d;
         rd_p1_q    <= rd_p1_d;
         wr_inc_q   <= wr_inc_d;
      end
   end

   // Next-state logic: bus events drive the byte/ACK sequencing, RAM strobes
   // post-increment the address one clock after they fire.
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      ack_slot_d = ack_slot_q;
      bit_seen_d = bit_seen_q;
      rw_d       = rw_q;
      mack_d     = mack_q;
      sh_d       = sh_q;
      ram_d_d    = ram_d_q;
      addr_d     = addr_q;
      sda_d      = sda_q;
      ram_wr_d   = 1'b0;
      ram_rd_d   = 1'b0;
      wr_inc_d   = 1'b0;
      rd_p1_d    = ram_rd_q;
      tx_d       = rd_p1_q ? ram_q : tx_q;
      bit_nxt    = bitcnt_q - 3'd1;
      pmask      = ~({ADDR_W{1'b1}} << page_bits);
      dev_match  = (sh_q[7:4] == DEV_CODE) &&
                   (!is_two_byte(mode) || (sh_q[3:1] == dev_sel));

      // The address is held through the strobe cycle, so the RAM sees the old value.
      if (ram_rd_q) begin
         addr_d = (addr_q + 1'b1) & mask;
      end else if (wr_inc_q) begin
         addr_d = (addr_q & ~pmask) | ((addr_q + 1'b1) & pmask);
      end

      if (stop_ev) begin
         state_d    = S_IDLE;
         sda_d      = 1'b1;
         ack_slot_d = 1'b0;
         bit_seen_d = 1'b0;
         bitcnt_d   = 3'd7;
      end else if (start_ev) begin
         state_d    = (mode == MODE_24C01) ? S_ADR7 : S_DEV;
         sda_d      = 1'b1;
         ack_slot_d = 1'b0;
         bit_seen_d = 1'b0;
         bitcnt_d   = 3'd7;
      end else if (state_q == S_IDLE || state_q == S_NACKWAIT) begin
         // Bus ignored until the next START or STOP.
      end else if (scl_rise) begin
         bit_seen_d = 1'b1;
         if (!ack_slot_q) begin
            sh_d = {sh_q[6:0], sda_hi};
         end else if (state_q == S_READ) begin
            mack_d   = !sda_hi;
            ram_rd_d = !sda_hi;
         end
      end else if (scl_fall && bit_seen_q) begin
         // Only falls that follow a sampled rise count, which skips the START fall.
         bit_seen_d = 1'b0;
         if (!ack_slot_q) begin
            if (bitcnt_q != 3'd0) begin
               bitcnt_d = bit_nxt;
               sda_d    = (state_q == S_READ) ? tx_q[bit_nxt] : 1'b1;
            end else begin
               bitcnt_d   = 3'd7;
               ack_slot_d = 1'b1;
               sda_d      = 1'b0;
               case (state_q)
                  S_ADR7: begin
                     addr_d[6:0] = sh_q[7:1];
                     rw_d        = sh_q[0];
                     ram_rd_d    = sh_q[0];
                  end
                  S_DEV: begin
                     if (dev_match) begin
                        rw_d     = sh_q[0];
                        ram_rd_d = sh_q[0];
                        if (mode == MODE_24C02) addr_d[10:8] = sh_q[3:1];
                     end else begin
                        state_d    = S_NACKWAIT;
                        sda_d      = 1'b1;
                        ack_slot_d = 1'b0;
                     end
                  end
                  S_AHI:   addr_d[ADDR_W-1:8] = HI_W'(sh_q);
                  S_ALO:   addr_d[7:0] = sh_q;
                  S_READ:  sda_d = 1'b1;
                  default: ;
               endcase
            end
         end else begin
            ack_slot_d = 1'b0;
            sda_d      = 1'b1;
            case (state_q)
               S_ADR7:  state_d = rw_q ? S_READ : S_WRITE;
               S_DEV:   state_d = rw_q ? S_READ : (is_two_byte(mode) ? S_AHI : S_ALO);
               S_AHI:   state_d = S_ALO;
               S_ALO:   state_d = S_WRITE;
               S_WRITE: begin
                  ram_wr_d = !wp;
                  ram_d_d  = sh_q;
                  wr_inc_d = 1'b1;
               end
               S_READ:  if (!mack_q) state_d = S_NACKWAIT;
               default: ;
            endcase
            if (state_d == S_READ) sda_d = tx_q[7];
         end
      end
   end

   assign sda_o     = sda_q;
   assign ram_addr  = addr_q & mask;
   assign ram_d     = ram_d_q;
   assign ram_wr    = ram_wr_q;
   assign ram_rd    = ram_rd_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Directed bench: bit-banged I2C master plus a simple BRAM model with access logs.
module tb_eeprom_i2c_slave;

   localparam int Q = 8;  // clocks per quarter bit

   logic        clk, rst, en, scl, m_sda, wp;
   logic [1:0]  mode;
   logic [15:0] mask;
   logic [2:0]  page_bits, dev_sel;
   logic        sda_o, ram_wr, ram_rd;
   logic [15:0] ram_addr;
   logic [7:0]  ram_d, ram_q;
   logic [2:0]  dbg_state;
   logic        sda_line;

   logic [7:0]  mem [0:65535];
   logic [15:0] rd_log[$];
   logic [15:0] wr_alog[$];
   logic [7:0]  wr_dlog[$];
   int          both_cnt;
   int          n_cmp, n_bad;

   assign sda_line = m_sda & sda_o;

   eeprom_i2c_slave #(.ADDR_W(16), .FILT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .mask      (mask),
      .page_bits (page_bits),
      .dev_sel   (dev_sel),
      .wp        (wp),
      .scl       (scl),
      .sda_i     (sda_line),
      .sda_o     (sda_o),
      .ram_addr  (ram_addr),
      .ram_d     (ram_d),
      .ram_wr    (ram_wr),
      .ram_rd    (ram_rd),
      .ram_q     (ram_q),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd) begin
         ram_q <= mem[ram_addr];
         rd_log.push_back(ram_addr);
      end
      if (ram_wr) begin
         mem[ram_addr] = ram_d;
         wr_alog.push_back(ram_addr);
         wr_dlog.push_back(ram_d);
      end
      if (ram_rd && ram_wr) both_cnt++;
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_alog.delete();
      wr_dlog.delete();
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      m_sda = 1'b0; wait_q();
      scl = 1'b0;   wait_q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_q();
      scl = 1'b1;   wait_q();
      m_sda = 1'b1; wait_q();
   endtask

   task automatic write_bit(input logic b);
      m_sda = b; wait_q();
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      m_sda = 1'b1; wait_q();
      scl = 1'b1; wait_q();
      ack = !sda_line;
      wait_q();
      scl = 1'b0; wait_q();
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         m_sda = 1'b1; wait_q();
         scl = 1'b1;   wait_q();
         b[i] = sda_line;
         wait_q();
         scl = 1'b0;   wait_q();
      end
      m_sda = !mack; wait_q();
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
      m_sda = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b expected 1", sda_o); end
      n_cmp++; if (ram_wr !== 1'b0 || ram_rd !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got wr=%b rd=%b expected 0/0", ram_wr, ram_rd); end
      n_cmp++; if (ram_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h expected 0000", ram_addr); end
      rst = 1'b0;
      wait_q();
   endtask

   task automatic test_mode0_write_read();
      logic       a0, a1;
      logic [7:0] rb;
      mode = 2'd0; mask = 16'hFFFF; page_bits = 3'd0;
      clear_logs();
      i2c_start();
      write_byte({7'h12, 1'b0}, a0);
      write_byte(8'h5A, a1);
      i2c_stop();
      n_cmp++; if ({a0, a1} !== 2'b11) begin n_bad++; $display("FAIL m0_write_ack: got %b expected 11", {a0, a1}); end
      n_cmp++; if (wr_alog.size() !== 1) begin n_bad++; $display("FAIL m0_write_count: got %0d expected 1", wr_alog.size()); end
      else begin
         n_cmp++; if (wr_alog[0] !== 16'h0012) begin n_bad++; $display("FAIL m0_write_addr: got %h expected 0012", wr_alog[0]); end
         n_cmp++; if (wr_dlog[0] !== 8'h5A) begin n_bad++; $display("FAIL m0_write_data: got %h expected 5a", wr_dlog[0]); end
      end
      n_cmp++; if (dbg_state !== 3'd0 || sda_o !== 1'b1) begin n_bad++; $display("FAIL m0_after_stop: got state=%0d sda=%b expected 0/1", dbg_state, sda_o); end
      clear_logs();
      i2c_start();
      write_byte({7'h12, 1'b1}, a0);
      read_byte(1'b0, rb);
      i2c_stop();
      n_cmp++; if (a0 !== 1'b1) begin n_bad++; $display("FAIL m0_read_ack: got %b expected 1", a0); end
      n_cmp++; if (rb !== 8'h5A) begin n_bad++; $display("FAIL m0_read_data: got %h expected 5a", rb); end
      n_cmp++; if (rd_log.size() !== 1) begin n_bad++; $display("FAIL m0_read_count: got %0d expected 1", rd_log.size()); end
      else begin
         n_cmp++; if (rd_log[0] !== 16'h0012) begin n_bad++; $display("FAIL m0_read_addr: got %h expected 0012", rd_log[0]); end
      end
   endtask

   task automatic test_mode2_devsel();
      logic a;
      mode = 2'd2; mask = 16'hFFFF; dev_sel = 3'b101;
      clear_logs();
      i2c_start();
      write_byte(8'hA8, a);
      n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL devsel_nack: got ack=%b expected 0", a); end
      n_cmp++; if (dbg_state !== 3'd7) begin n_bad++; $display("FAIL devsel_nackwait: got %0d expected 7", dbg_state); end
      i2c_stop();
      n_cmp++; if (rd_log.size() + wr_alog.size() !== 0) begin n_bad++; $display("FAIL devsel_no_ram: got %0d accesses expected 0", rd_log.size() + wr_alog.size()); end
      i2c_start();
      write_byte(8'hAA, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL devsel_ack: got ack=%b expected 1", a); end
      n_cmp++; if (dbg_state !== 3'd3) begin n_bad++; $display("FAIL devsel_ahi: got %0d expected 3", dbg_state); end
      i2c_stop();
   endtask

   task automatic test_page_write();
      logic        a;
      logic [15:0] exp_a [10];
      exp_a = '{16'h0FE, 16'h0FF, 16'h0F8, 16'h0F9, 16'h0FA,
                16'h0FB, 16'h0FC, 16'h0FD, 16'h0FE, 16'h0FF};
      mode = 2'd1; mask = 16'h07FF; page_bits = 3'd3;
      clear_logs();
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'hFE, a);
      for (int i = 0; i < 10; i++) write_byte(8'h30 + 8'(i), a);
      i2c_stop();
      n_cmp++; if (wr_alog.size() !== 10) begin n_bad++; $display("FAIL page_count: got %0d expected 10", wr_alog.size()); end
      else begin
         for (int i = 0; i < 10; i++) begin
            n_cmp++; if (wr_alog[i] !== exp_a[i]) begin n_bad++; $display("FAIL page_addr[%0d]: got %h expected %h", i, wr_alog[i], exp_a[i]); end
            n_cmp++; if (wr_dlog[i] !== 8'h30 + 8'(i)) begin n_bad++; $display("FAIL page_data[%0d]: got %h expected %h", i, wr_dlog[i], 8'h30 + 8'(i)); end
         end
      end
      page_bits = 3'd0;
   endtask

   task automatic test_seq_read();
      logic       a;
      logic [7:0] r0, r1, r2;
      mode = 2'd2; mask = 16'h0FFF; dev_sel = 3'b000;
      mem[16'h0FFF] = 8'hC1; mem[16'h0000] = 8'hC2; mem[16'h0001] = 8'hC3;
      clear_logs();
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h0F, a);
      write_byte(8'hFF, a);
      i2c_start();
      write_byte(8'hA1, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL seq_dev_ack: got %b expected 1", a); end
      read_byte(1'b1, r0);
      read_byte(1'b1, r1);
      read_byte(1'b0, r2);
      n_cmp++; if ({r0, r1, r2} !== 24'hC1C2C3) begin n_bad++; $display("FAIL seq_data: got %h expected c1c2c3", {r0, r1, r2}); end
      n_cmp++; if (sda_o !== 1'b1 || dbg_state !== 3'd7) begin n_bad++; $display("FAIL seq_nack_release: got sda=%b state=%0d expected 1/7", sda_o, dbg_state); end
      i2c_stop();
      n_cmp++; if (rd_log.size() !== 3) begin n_bad++; $display("FAIL seq_rd_count: got %0d expected 3", rd_log.size()); end
      else begin
         n_cmp++; if ({rd_log[0], rd_log[1], rd_log[2]} !== {16'h0FFF, 16'h0000, 16'h0001}) begin
            n_bad++; $display("FAIL seq_rd_addr: got %h %h %h expected 0fff 0000 0001", rd_log[0], rd_log[1], rd_log[2]);
         end
      end
      n_cmp++; if (wr_alog.size() !== 0) begin n_bad++; $display("FAIL seq_no_write: got %0d expected 0", wr_alog.size()); end
   endtask

   task automatic test_wp();
      logic a;
      int   acks;
      mode = 2'd2; mask = 16'hFFFF; dev_sel = 3'b000; wp = 1'b1;
      clear_logs();
      acks = 0;
      i2c_start();
      write_byte(8'hA0, a); acks += int'(a);
      write_byte(8'h00, a); acks += int'(a);
      write_byte(8'h10, a); acks += int'(a);
      write_byte(8'h11, a); acks += int'(a);
      write_byte(8'h22, a); acks += int'(a);
      write_byte(8'h33, a); acks += int'(a);
      i2c_stop();
      n_cmp++; if (acks !== 6) begin n_bad++; $display("FAIL wp_acks: got %0d expected 6", acks); end
      n_cmp++; if (wr_alog.size() !== 0) begin n_bad++; $display("FAIL wp_no_write: got %0d expected 0", wr_alog.size()); end
      wp = 1'b0;
   endtask

   task automatic test_abort();
      logic a;
      mode = 2'd2; mask = 16'hFFFF; dev_sel = 3'b000;
      clear_logs();
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h00, a);
      write_byte(8'h20, a);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      i2c_stop();
      n_cmp++; if (dbg_state !== 3'd0 || sda_o !== 1'b1) begin n_bad++; $display("FAIL stop_midbyte: got state=%0d sda=%b expected 0/1", dbg_state, sda_o); end
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h00, a);
      write_byte(8'h20, a);
      for (int i = 7; i >= 0; i--) write_bit(i[0]);
      n_cmp++; if (sda_o !== 1'b0) begin n_bad++; $display("FAIL ack_driven: got sda=%b expected 0", sda_o); end
      rst = 1'b1; en = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (dbg_state !== 3'd0 || sda_o !== 1'b1 || ram_addr !== 16'h0000) begin
         n_bad++; $display("FAIL rst_midwrite: got state=%0d sda=%b addr=%h expected 0/1/0000", dbg_state, sda_o, ram_addr);
      end
      rst = 1'b0; en = 1'b1;
      scl = 1'b1; wait_q();
      m_sda = 1'b1; wait_q(); wait_q();
      n_cmp++; if (wr_alog.size() !== 0) begin n_bad++; $display("FAIL abort_no_write: got %0d expected 0", wr_alog.size()); end
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL rd_wr_overlap: got %0d expected 0", both_cnt); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; both_cnt = 0;
      rst = 1'b1; en = 1'b1; scl = 1'b1; m_sda = 1'b1; wp = 1'b0;
      mode = 2'd0; mask = 16'hFFFF; page_bits = 3'd0; dev_sel = 3'd0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_mode0_write_read();
      test_mode2_devsel();
      test_page_write();
      test_seq_read();
      test_wp();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/eeprom_i2c_slave.md
EEPROM_I2C_SLAVE -- requirements
Module: eeprom_i2c_slave

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of the BRAM address and of the internal word address.
REQ-002 Parameter FILT, default 4, SHALL set the SDA/SCL edge-filter depth in en-qualified samples (even, >=2).
REQ-003 clk  in  1  bus clock; the block SHALL use this single clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  sample enable; when low, filters, counters and state SHALL hold.
REQ-006 mode  in  2  device class: 0 = 24C01 (7-bit address in first byte); 1 = 24C02..16 (1 address byte, block bits in device byte); 2 = 24C32+ (2 address bytes); 3 = treated as 2.
REQ-007 mask  in  ADDR_W  capacity mask applied to every ram_addr.
REQ-008 page_bits  in  3  write-page size is 2^page_bits bytes (0 = 1 byte).
REQ-009 dev_sel  in  3  chip-select pins A2..A0, matched in mode 2 only.
REQ-010 wp  in  1  write protect: data bytes still ACKed, RAM writes suppressed.
REQ-011 scl, sda_i  in  1 each  bus inputs; sda_o  out  1  open-drain drive (0 = pull low).
REQ-012 ram_addr out ADDR_W; ram_d out 8; ram_wr out 1; ram_rd out 1; ram_q in 8 (read data valid 1 clk after ram_rd).
REQ-013 dbg_state  out  3  current FSM state encoding.

Function
REQ-014 Edge detection SHALL use FILT-deep shift registers: rise = older half all 0 and newer half all 1; fall = inverse; high = all 1.
REQ-015 START SHALL be sda fall while scl high, in any state, including mid-byte (repeated start); the FSM SHALL enter DEV (mode 1/2) or ADR7 (mode 0) with bit counter = 7.
REQ-016 STOP SHALL be sda rise while scl high; the FSM SHALL return to IDLE from any state, releasing sda_o within 1 clk.
REQ-017 Bits SHALL be sampled MSB-first on scl rise; the counter SHALL decrement on scl fall; the 9th clock is the ACK slot.
REQ-018 States: IDLE, ADR7, DEV, AHI, ALO, WRITE, READ, NACKWAIT.
REQ-019 ADR7: addr[6:0] = byte[7:1]; R/W = byte[0]; ACK; -> READ or WRITE.
REQ-020 DEV: byte[7:4] SHALL equal 4'b1010, and in mode 2 byte[3:1] SHALL equal dev_sel; on mismatch no ACK, -> NACKWAIT (bus released until START/STOP).
REQ-021 DEV, mode 1: addr[10:8] = byte[3:1]; write -> ALO; read -> READ, keeping the current addr[7:0].
REQ-022 DEV, mode 2: write -> AHI -> ALO (addr[ADDR_W-1:8], addr[7:0]); read -> READ.
REQ-023 After ALO the FSM SHALL enter WRITE; a START there SHALL re-enter DEV (random read).
REQ-024 WRITE: every data byte SHALL be ACKed; on the ACK scl fall, ram_wr SHALL pulse 1 clk with ram_d = byte (suppressed if wp=1). The low page_bits of addr SHALL then increment, wrapping within the page; upper bits unchanged.
REQ-025 READ: on entry, and after each master ACK (sda low sampled at 9th scl rise), ram_rd SHALL pulse 1 clk and the shift register SHALL load ram_q 2 clk later; the full address SHALL increment after the ACK, wrapping modulo mask.
REQ-026 READ: sda_o SHALL present the data bit from the scl fall preceding each bit and SHALL be 1 in the ACK slot; a master NACK SHALL go to NACKWAIT.
REQ-027 The slave ACK SHALL drive sda_o=0 from the 8th-bit scl fall to the 9th-bit scl fall; otherwise sda_o=1 outside READ data bits.
REQ-028 ram_addr SHALL always equal addr & mask; ram_wr and ram_rd SHALL never assert in the same cycle.

Reset
REQ-029 rst SHALL force: state IDLE, addr 0, sda_o 1, ram_wr 0, ram_rd 0, filters all 1, bit counter 7.
REQ-030 rst mid-byte SHALL abort without a RAM write; rst overrides en.

Structure
REQ-031 Package eeprom_pkg SHALL hold the state enum, mode constants and DEV_CODE = 4'b1010.
REQ-032 Filtering plus START/STOP/edge detection SHALL live in sub-module i2c_bus_monitor.

Verification
REQ-033 Mode 0, write 0x5A at 0x12, then read back -> ram_wr once at ram_addr 0x12 with ram_d 0x5A; read returns 0x5A.
REQ-034 Mode 2, dev_sel=3'b101, device byte 0xA8 -> no ACK, no RAM access; device byte 0xAA -> ACK.
REQ-035 Mode 1, page_bits=3, write 10 bytes from 0x0FE -> addresses 0x0FE, 0x0FF, 0x0F8..0x0FF.
REQ-036 Mode 2, mask=0x0FFF, sequential read from 0x0FFF with 2 master ACKs -> ram_rd addresses 0x0FFF, 0x0000, 0x0001; NACK then releases sda.
REQ-037 wp=1, 3-byte write -> all ACKed, ram_wr never asserts.
REQ-038 STOP mid-byte and rst mid-write -> IDLE, sda_o=1, no ram_wr.
